// File: rtl/video_xy_counter.sv
// Pixel column/line tracker for the AXI-Stream video generator.
// Optional VIDEO_XY_COUNTER_FRAME_CNT_EN adds a 32-bit completed-frame counter.
module video_xy_counter #(
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               continuous_i,
  input  logic [X_WIDTH-1:0] width_i,
  input  logic [Y_WIDTH-1:0] height_i,
  input  logic               step_i,
  output logic [X_WIDTH-1:0] x_o,
  output logic [Y_WIDTH-1:0] y_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               busy_o,
`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
  output logic [31:0]        frame_cnt_o,
`endif
  output logic               cfg_err_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [X_WIDTH-1:0] width_q, width_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [Y_WIDTH-1:0] height_q, height_d;
  logic               stop_pend_q, stop_pend_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ok;
  logic               last_x;
  logic               last_y;

  assign cfg_ok = (|width_i) && (|height_i);
  assign last_x = x_q == width_q - X_WIDTH'(1);
  assign last_y = y_q == height_q - Y_WIDTH'(1);

  assign busy_o    = state_q == S_RUN;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign sof_o     = busy_o && (x_q == '0) && (y_q == '0);
  assign eol_o     = busy_o && last_x;
  assign eof_o     = eol_o && last_y;
  assign cfg_err_o = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    width_d     = width_q;
    height_d    = height_q;
    stop_pend_d = stop_pend_q;
    cfg_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            width_d  = width_i;
            height_d = height_i;
            x_d      = '0;
            y_d      = '0;
            state_d  = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (step_i) begin
          if (!last_x) begin
            x_d = x_q + X_WIDTH'(1);
          end else if (!last_y) begin
            x_d = '0;
            y_d = y_q + Y_WIDTH'(1);
          end else begin
            x_d = '0;
            y_d = '0;
            // A stop seen on the final beat still ends the stream here.
            if (continuous_i && !stop_pend_q && !stop_i) begin
              if (cfg_ok) begin
                width_d  = width_i;
                height_d = height_i;
              end else begin
                state_d     = S_IDLE;
                cfg_err_d   = 1'b1;
                stop_pend_d = 1'b0;
              end
            end else begin
              state_d     = S_IDLE;
              stop_pend_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_o = frame_cnt_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (step_i && eof_o) frame_cnt_d = frame_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      width_q     <= '0;
      height_q    <= '0;
      stop_pend_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stop_pend_q <= stop_pend_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_video_xy_counter.sv
// Directed bench for video_xy_counter with hand-computed expectations.
// Frame counter checks run when VIDEO_XY_COUNTER_FRAME_CNT_EN is defined.
module tb_video_xy_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cont;
  logic [11:0] w;
  logic [11:0] h;
  logic        step;
  logic [11:0] x;
  logic [11:0] y;
  logic        sof;
  logic        eol;
  logic        eof;
  logic        busy;
  logic        cfg_err;
`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
  logic [31:0] frame_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  video_xy_counter #(.X_WIDTH(12), .Y_WIDTH(12)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_i       (stop),
    .continuous_i (cont),
    .width_i      (w),
    .height_i     (h),
    .step_i       (step),
    .x_o          (x),
    .y_o          (y),
    .sof_o        (sof),
    .eol_o        (eol),
    .eof_o        (eof),
    .busy_o       (busy),
`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
    .frame_cnt_o  (frame_cnt),
`endif
    .cfg_err_o    (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; cont = 0;
    w = 0; h = 0; step = 0;
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {sof, eol, eof, cfg_err}, 0);
`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
    chk("rst_fcnt", frame_cnt, 0);
`endif

    // 4x3 single frame, step held high
    w = 4; h = 3; cont = 0; step = 1; start = 1;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 12; k++) begin
      chk("t1_x", x, k % 4);
      chk("t1_y", y, k / 4);
      chk("t1_sof", sof, k == 0);
      chk("t1_eol", eol, (k % 4) == 3);
      chk("t1_eof", eof, k == 11);
      tick();
    end
    chk("t1_idle", busy, 0);
    chk("t1_x0", x, 0);
    chk("t1_y0", y, 0);

    // 4x3 with step toggling
    step = 0; start = 1;
    tick();
    start = 0;
    n = 0;
    for (int i = 0; i < 23; i++) begin
      step = (i % 2) == 0;
      chk("t2_busy", busy, 1);
      chk("t2_x", x, n % 4);
      chk("t2_y", y, n / 4);
      chk("t2_eof", eof, n == 11);
      if (step) n++;
      tick();
    end
    chk("t2_idle", busy, 0);

    // continuous 2x2, width changed mid-frame, stop in frame 2
    w = 2; h = 2; cont = 1; step = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    w = 3;
    tick();
    chk("t3_f1_x", x, 1);
    chk("t3_f1_y", y, 1);
    chk("t3_f1_eof", eof, 1);
    tick();
    chk("t3_f2_busy", busy, 1);
    chk("t3_f2_sof", sof, 1);
    chk("t3_f2_xy", {x, y}, 0);
    tick();
    stop = 1;
    chk("t3_b2_x", x, 1);
    chk("t3_b2_eol", eol, 0);
    tick();
    stop = 0;
    chk("t3_b3_x", x, 2);
    chk("t3_b3_eol", eol, 1);
    chk("t3_b3_eof", eof, 0);
    tick(); tick(); tick();
    chk("t3_b6_x", x, 2);
    chk("t3_b6_y", y, 1);
    chk("t3_b6_eof", eof, 1);
    tick();
    chk("t3_idle", busy, 0);
    cont = 0;

    // zero dimension rejected
    w = 0; h = 5; step = 0; start = 1;
    tick();
    start = 0;
    chk("t4_cfg_err", cfg_err, 1);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_cfg_err_clr", cfg_err, 0);
    chk("t4_busy2", busy, 0);

    // 1x1 frame
    w = 1; h = 1; step = 1; start = 1;
    tick();
    start = 0;
    chk("t4_1x1_busy", busy, 1);
    chk("t4_1x1_flags", {sof, eol, eof}, 3'b111);
    tick();
    chk("t4_1x1_idle", busy, 0);

    // reset mid-frame at x=2,y=1
    w = 4; h = 3; step = 1; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_x", x, 2);
    chk("t5_y", y, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_xy", {x, y}, 0);
    chk("t5_flags", {sof, eol, eof}, 0);
    w = 2; h = 1; start = 1;
    tick();
    start = 0;
    chk("t5_busy2", busy, 1);
    chk("t5_sof", sof, 1);
    chk("t5_eol0", eol, 0);
    tick();
    chk("t5_x1", x, 1);
    chk("t5_eof", {eol, eof}, 2'b11);
    tick();
    chk("t5_idle", busy, 0);

`ifdef VIDEO_XY_COUNTER_FRAME_CNT_EN
    rst = 1;
    tick();
    rst = 0;
    w = 2; h = 2; cont = 1; step = 1; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 11; k++) tick();
    stop = 1;
    chk("fc_eof", eof, 1);
    tick();
    stop = 0;
    cont = 0;
    chk("fc_idle", busy, 0);
    chk("fc_three", frame_cnt, 3);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt_q;
    w = 1; h = 1; start = 1;
    tick();
    start = 0;
    chk("fc_pre", frame_cnt, 32'hFFFF_FFFF);
    tick();
    chk("fc_wrap", frame_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_xy_counter.md
Name: video_xy_counter

Overview:
- Parametrised two-dimensional successor to the free-running up-counter. Tracks pixel column (x) and line (y) position inside a frame of runtime-programmable size.
- Advances only on an accepted pixel step, and emits start-of-frame, end-of-line and end-of-frame markers.
- Sits inside the AXI-Stream video generator. The generator drives step_i from its tvalid&tready beat and maps sof_o/eol_o to tuser/tlast.

Parameters:
- X_WIDTH, 12, bit width of the column counter and of width_i (max 4095 px/line)
- Y_WIDTH, 12, bit width of the line counter and of height_i (max 4095 lines)

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle request to begin a frame; latches width_i/height_i
- stop_i  input  1  request to halt after the current frame completes
- continuous_i  input  1  1 = roll into the next frame automatically; 0 = single frame
- width_i  input  X_WIDTH  pixels per line, sampled only at frame boundaries
- height_i  input  Y_WIDTH  lines per frame, sampled only at frame boundaries
- step_i  input  1  advance one pixel; ignored unless busy_o=1
- x_o  output  X_WIDTH  current column
- y_o  output  Y_WIDTH  current line
- sof_o  output  1  busy_o & x_o==0 & y_o==0
- eol_o  output  1  busy_o & x_o==width_q-1
- eof_o  output  1  eol_o & y_o==height_q-1
- busy_o  output  1  1 while in RUN state
- cfg_err_o  output  1  one-cycle pulse when start is rejected for a zero dimension

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; x_o=0, y_o=0; width_q=0, height_q=0, stop_pend=0. All outputs are 0. Reset has priority over every other input, including mid-frame.
- States are IDLE and RUN.
- IDLE:
  - start_i=1 with width_i!=0 and height_i!=0: latch width_q/height_q, x=y=0, go to RUN next cycle. busy_o=1 the cycle after start_i.
  - start_i=1 with a zero dimension: stay in IDLE, cfg_err_o=1 for one cycle.
  - step_i and stop_i are ignored.
- RUN, step_i=0: hold all state. Flags remain valid combinationally from the registers (zero-latency markers).
- RUN, step_i=1:
  - x<width_q-1: x<=x+1.
  - x==width_q-1 and y<height_q-1: x<=0, y<=y+1.
  - Last pixel (eof_o=1):
    - If continuous_i=1 and stop_pend=0 and stop_i=0: x<=0, y<=0, re-latch width_i/height_i. If the new value has a zero dimension, go to IDLE and pulse cfg_err_o.
    - Otherwise: go to IDLE, x<=0, y<=0, clear stop_pend.
- stop_i in RUN sets stop_pend. The frame always completes; there is no early abort other than reset. stop_i coincident with the last step counts as a stop.
- start_i while in RUN is ignored.
- Configuration is never taken mid-frame: changes to width_i/height_i during RUN take effect only at the next boundary.
- Width 1: eol_o is asserted on every pixel. Height 1: eof_o coincides with every eol_o. 1x1: sof_o, eol_o and eof_o are all high together.
- Counters never exceed width_q-1/height_q-1. There is no modulo-2^N wrap inside a frame.

Optional Feature:
- Macro VIDEO_XY_COUNTER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_o [31:0], reset to 0 by rst_i only.
  - Increments by 1 on each completed frame (step_i & eof_o), wrapping from 0xFFFFFFFF to 0.
  - Not cleared by start_i.
- Undefined: port and register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then start_i with width=4, height=3, continuous=0, step_i held high:
  - busy_o=1 one cycle after start.
  - sof_o on the first beat only; eol_o at x=3 on each line.
  - eof_o on beat 12.
  - IDLE after beat 12 with x=y=0.
- Same 4x3 with step_i toggling 1/0: positions hold on step_i=0 cycles. Total of 12 accepted steps reaches eof_o.
- Continuous=1, width=2, height=2; width_i changed to 3 mid-frame:
  - First frame still completes at 4 steps.
  - Second frame eol_o at x=2.
  - stop_i pulse during the second frame ends in IDLE after its 6th step.
- start_i with width=0, height=5: cfg_err_o=1 for one cycle, busy_o stays 0. Also test start_i with width=1, height=1: sof_o, eol_o and eof_o all high on the single step.
- rst_i asserted at x=2, y=1 of a running frame: next cycle busy_o=0, x=y=0, all flags 0. The following start_i runs normally.
- Macro defined: 3 continuous 2x2 frames give frame_cnt_o=3. Preload the counter near 0xFFFFFFFF via force and check it wraps to 0.
